// File: rtl/tpu_tile_scheduler_pkg.sv
// Shared sizing, FSM encoding and small arithmetic helpers for the TPU tile scheduler.
package tpu_tile_scheduler_pkg;

    localparam int PE_DIM          = 4;
    localparam int GBUFF_ADDR_SIZE = 8;
    localparam int DRAIN_LEN       = 2 * PE_DIM - 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    function automatic logic [7:0] mul4x4(input logic [3:0] a, input logic [3:0] b);
        return {4'b0000, a} * {4'b0000, b};
    endfunction

    function automatic logic [2:0] ceil_div4(input logic [3:0] x);
        logic [4:0] s;
        s = {1'b0, x} + 5'd3;
        return s[4:2];
    endfunction

endpackage

// File: rtl/tpu_tile_scheduler_tile_counter.sv
// Nested tile counters: row tile r, column tile c, step t (LOAD/DRAIN), write row i.
// Flags are combinational from the current counts; counts update on the clock edge.
module tpu_tile_scheduler_tile_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       t_inc,
    input  logic       t_clr,
    input  logic       i_inc,
    input  logic       i_clr,
    input  logic       tile_next,
    input  logic [3:0] t_lim,
    input  logic [2:0] i_lim,
    input  logic [2:0] ct,
    input  logic [2:0] rt,
    output logic [1:0] r,
    output logic [1:0] c,
    output logic [3:0] t,
    output logic [1:0] i,
    output logic       t_last,
    output logic       i_last,
    output logic       c_last,
    output logic       r_last
);

    assign t_last = (t == t_lim - 4'd1);
    assign i_last = ({1'b0, i} == i_lim - 3'd1);
    assign c_last = ({1'b0, c} == ct - 3'd1);
    assign r_last = ({1'b0, r} == rt - 3'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r <= '0;
            c <= '0;
            t <= '0;
            i <= '0;
        end else if (clear) begin
            r <= '0;
            c <= '0;
            t <= '0;
            i <= '0;
        end else begin
            if (t_clr)      t <= '0;
            else if (t_inc) t <= t + 4'd1;
            if (i_clr)      i <= '0;
            else if (i_inc) i <= i + 2'd1;
            // column tile is the inner loop; wrapping it steps the row tile
            if (tile_next) begin
                if (c_last) begin
                    c <= '0;
                    r <= r + 2'd1;
                end else begin
                    c <= c + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/tpu_tile_scheduler.sv
// Tile-by-tile sequencer for the 4x4 systolic array: A/B reads, PE clear/feed, output row writes.
// Per tile 1 + k + DRAIN_CYCLES + rows cycles; start is ignored while busy.
module tpu_tile_scheduler
    import tpu_tile_scheduler_pkg::*;
#(
    parameter int ARRAY_SIZE   = PE_DIM,
    parameter int ADDR_W       = GBUFF_ADDR_SIZE,
    parameter int DRAIN_CYCLES = DRAIN_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        m,
    input  logic [3:0]        k,
    input  logic [3:0]        n,
    output logic              done,
    output logic              busy,
    output logic              a_rd,
    output logic [ADDR_W-1:0] a_addr,
    output logic              b_rd,
    output logic [ADDR_W-1:0] b_addr,
    output logic              pe_clear,
    output logic              pe_feed,
    output logic [1:0]        pe_row_sel,
    output logic              out_wr,
    output logic [ADDR_W-1:0] out_addr
);

    state_t     state, state_nxt;
    logic [3:0] m_q, k_q;
    logic [2:0] rt_q, ct_q;
    logic       accept, dims_zero;
    logic       cnt_clear, t_inc, t_clr, i_inc, i_clr, tile_next;
    logic [1:0] r, c, i;
    logic [3:0] t, t_lim;
    logic [2:0] rows;
    logic [4:0] rows_left;
    logic       t_last, i_last, c_last, r_last;

    assign accept    = start && (state == ST_IDLE || state == ST_DONE);
    assign dims_zero = (m == 4'd0) || (k == 4'd0) || (n == 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            m_q     <= '0;
            k_q     <= '0;
            rt_q    <= '0;
            ct_q    <= '0;
            pe_feed <= 1'b0;
        end else begin
            state   <= state_nxt;
            // buffer read data arrives one cycle after the strobe
            pe_feed <= a_rd;
            if (accept) begin
                m_q  <= m;
                k_q  <= k;
                rt_q <= ceil_div4(m);
                ct_q <= ceil_div4(n);
            end
        end
    end

    // rows written for the current row tile: min(ARRAY_SIZE, m - 4r)
    assign rows_left = {1'b0, m_q} - {1'b0, r, 2'b00};
    assign rows      = (rows_left > 5'(ARRAY_SIZE)) ? 3'(ARRAY_SIZE) : rows_left[2:0];
    assign t_lim     = (state == ST_LOAD) ? k_q : 4'(DRAIN_CYCLES);

    tpu_tile_scheduler_tile_counter u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (cnt_clear),
        .t_inc     (t_inc),
        .t_clr     (t_clr),
        .i_inc     (i_inc),
        .i_clr     (i_clr),
        .tile_next (tile_next),
        .t_lim     (t_lim),
        .i_lim     (rows),
        .ct        (ct_q),
        .rt        (rt_q),
        .r         (r),
        .c         (c),
        .t         (t),
        .i         (i),
        .t_last    (t_last),
        .i_last    (i_last),
        .c_last    (c_last),
        .r_last    (r_last)
    );

    always_comb begin
        state_nxt = state;
        a_rd      = 1'b0;
        b_rd      = 1'b0;
        pe_clear  = 1'b0;
        out_wr    = 1'b0;
        cnt_clear = 1'b0;
        t_inc     = 1'b0;
        t_clr     = 1'b0;
        i_inc     = 1'b0;
        i_clr     = 1'b0;
        tile_next = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    cnt_clear = 1'b1;
                    state_nxt = dims_zero ? ST_DONE : ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                pe_clear  = 1'b1;
                state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                a_rd = 1'b1;
                b_rd = 1'b1;
                if (t_last) begin
                    t_clr     = 1'b1;
                    state_nxt = ST_DRAIN;
                end else begin
                    t_inc = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (t_last) begin
                    t_clr     = 1'b1;
                    state_nxt = ST_WRITE;
                end else begin
                    t_inc = 1'b1;
                end
            end
            ST_WRITE: begin
                out_wr = 1'b1;
                if (i_last) begin
                    i_clr = 1'b1;
                    if (c_last && r_last) begin
                        state_nxt = ST_DONE;
                    end else begin
                        tile_next = 1'b1;
                        state_nxt = ST_CLEAR;
                    end
                end else begin
                    i_inc = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign done       = (state == ST_DONE);
    assign busy       = (state != ST_IDLE) && (state != ST_DONE);
    assign a_addr     = a_rd   ? ADDR_W'(mul4x4({2'b00, r}, k_q) + 8'(t)) : '0;
    assign b_addr     = b_rd   ? ADDR_W'(mul4x4({2'b00, c}, k_q) + 8'(t)) : '0;
    assign out_addr   = out_wr ? ADDR_W'(mul4x4({r, i}, {1'b0, ct_q}) + 8'(c)) : '0;
    assign pe_row_sel = out_wr ? i : 2'b00;

endmodule
